ecp5pll_phase_ctrl: RTL and testbench

ECP5PLL_PHASE_CTRL -- requirements
Module: ecp5pll_phase_ctrl

---
 rtl/ecp5pll_phase_pkg.sv | 22 ++
 rtl/ecp5pll_phase_timer.sv | 34 +++
 rtl/ecp5pll_phase_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ecp5pll_phase_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecp5pll_phase_pkg.sv
// Shared types for the ECP5 PLL dynamic phase controller: FSM state encoding,
// fine-step position type and a helper used to size the shared timer.
package ecp5pll_phase_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    LOAD  = 3'd4
  } state_t;

  typedef logic [9:0] pos_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ecp5pll_phase_timer.sv
// Loadable down-counter with zero flag; the single cycle timer shared by all
// controller states. Holds at zero until reloaded.
module ecp5pll_phase_timer #(
  parameter int unsigned width = 3
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_val,
  output logic             zero
);

  logic [width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// ECP5 PLL dynamic phase-step sequencer: drives phasesel/phasedir/phasestep/
// phaseloadreg and tracks per-output fine position. Optional lock gating is
// compiled in with ECP5PLL_PHASE_LOCKWAIT_EN.
module ecp5pll_phase_ctrl
  import ecp5pll_phase_pkg::*;
#(
  parameter int unsigned setup_cycles = 2,
  parameter int unsigned pulse_cycles = 4,
  parameter int unsigned gap_cycles   = 4
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic       req_load,
  input  logic [7:0] req_steps,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  input  logic       locked,
  output logic       done,
  output logic       busy,
  output logic [9:0] pos0,
  output logic [9:0] pos1,
  output logic [9:0] pos2,
  output logic [9:0] pos3
);

  localparam int unsigned TMAX = max3(setup_cycles, pulse_cycles, gap_cycles);
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  // Timer is loaded with (duration - 1) so a state lasts exactly its duration.
  localparam logic [TW-1:0] SETUP_LD = TW'(setup_cycles - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(pulse_cycles - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(gap_cycles - 1);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        dir_q, dir_d;
  logic        load_q, load_d;
  logic [7:0]  steps_q, steps_d;
  logic        done_q, done_d;
  pos_t        pos_q [4];
  pos_t        pos_d [4];
  logic        tmr_load;
  logic [TW-1:0] tmr_val;
  logic        tmr_zero;
  logic        lock_lost;
  logic        ready;

`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
  logic abort_q, abort_d;
  assign ready = (state_q == IDLE) && !reset && locked;
`else
  logic unused_locked;
  assign unused_locked = locked;
  assign ready = (state_q == IDLE) && !reset;
`endif

  ecp5pll_phase_timer #(.width(TW)) u_timer (
    .clk_i    (clk_i),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    load_d   = load_q;
    steps_d  = steps_q;
    pos_d    = pos_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
    // Lock loss is sticky for the rest of the sequence.
    abort_d   = abort_q | (!locked && (state_q == SETUP || state_q == PULSE || state_q == GAP));
    lock_lost = abort_d;
`else
    lock_lost = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
        abort_d   = 1'b0;
        lock_lost = 1'b0;
`endif
        if (req_valid && ready) begin
          sel_d    = req_sel;
          dir_d    = req_dir;
          load_d   = req_load;
          steps_d  = req_steps;
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (lock_lost) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmr_zero) begin
          if (load_q) begin
            state_d  = LOAD;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LD;
          end else if (steps_q == 8'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LD;
          end
        end
      end
      PULSE: begin
        // Leaving PULSE is the phasestep falling edge: position moves here.
        if (tmr_zero) begin
          pos_d[sel_q] = dir_q ? pos_q[sel_q] + 10'd1 : pos_q[sel_q] - 10'd1;
          steps_d      = steps_q - 8'd1;
          if (lock_lost) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end
      end
      GAP: begin
        if (lock_lost) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmr_zero) begin
          if (steps_q != 8'd0) begin
            state_d  = PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (tmr_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      steps_q <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) pos_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      steps_q <= steps_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < 4; i++) pos_q[i] <= pos_d[i];
    end
  end

`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
  always_ff @(posedge clk_i) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end
`endif

  assign req_ready    = ready;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = (state_q == PULSE);
  assign phaseloadreg = (state_q == LOAD);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign pos0         = pos_q[0];
  assign pos1         = pos_q[1];
  assign pos2         = pos_q[2];
  assign pos3         = pos_q[3];

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed self-checking bench for ecp5pll_phase_ctrl (default parameters).
// Lock-gating scenario is exercised only when ECP5PLL_PHASE_LOCKWAIT_EN is set.
module tb_ecp5pll_phase_ctrl;

  logic       clk_i = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sel = 2'd0;
  logic       req_dir = 1'b0;
  logic       req_load = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic [1:0] phasesel;
  logic       phasedir, phasestep, phaseloadreg;
  logic       locked = 1'b1;
  logic       done, busy;
  logic [9:0] pos0, pos1, pos2, pos3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  ecp5pll_phase_ctrl #(.setup_cycles(2), .pulse_cycles(4), .gap_cycles(4)) dut (
    .clk_i(clk_i), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_load(req_load), .req_steps(req_steps),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .locked(locked), .done(done), .busy(busy),
    .pos0(pos0), .pos1(pos1), .pos2(pos2), .pos3(pos3)
  );

  // Presents a request at the falling edge; transfer happens on the next rising edge.
  task automatic start_req(input logic [1:0] s, input logic d, input logic l, input logic [7:0] n);
    @(negedge clk_i);
    req_sel = s; req_dir = d; req_load = l; req_steps = n; req_valid = 1'b1;
    @(posedge clk_i);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({phasestep, phaseloadreg, done, busy, phasesel, phasedir} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_outs got %b want 0000000", {phasestep, phaseloadreg, done, busy, phasesel, phasedir});
    end
    vectors++;
    if ({pos0, pos1, pos2, pos3} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_pos got %h want 0", {pos0, pos1, pos2, pos3});
    end
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_low got %b want 0", req_ready);
    end
    @(negedge clk_i) reset = 1'b0;
    @(posedge clk_i); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_high got %b want 1", req_ready);
    end
  endtask

  task automatic test_steps3;
    logic exp_step;
    start_req(2'd1, 1'b1, 1'b0, 8'd3);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk_i); #1;
      exp_step = (k >= 2 && k < 26 && ((k - 2) % 8) < 4);
      vectors++;
      if (phasestep !== exp_step) begin
        miscompares++;
        $display("FAIL steps3_phasestep k=%0d got %b want %b", k, phasestep, exp_step);
      end
      vectors++;
      if (done !== (k == 26)) begin
        miscompares++;
        $display("FAIL steps3_done k=%0d got %b want %b", k, done, (k == 26));
      end
      vectors++;
      if (busy !== (k < 26)) begin
        miscompares++;
        $display("FAIL steps3_busy k=%0d got %b want %b", k, busy, (k < 26));
      end
      vectors++;
      if ({phasesel, phasedir, phaseloadreg} !== 4'b0110) begin
        miscompares++;
        $display("FAIL steps3_selDir k=%0d got %b want 0110", k, {phasesel, phasedir, phaseloadreg});
      end
    end
    vectors++;
    if ({pos0, pos1, pos2, pos3} !== {10'd0, 10'd3, 10'd0, 10'd0}) begin
      miscompares++;
      $display("FAIL steps3_pos got %0d %0d %0d %0d want 0 3 0 0", pos0, pos1, pos2, pos3);
    end
  endtask

  task automatic test_wrap;
    int done_k;
    @(negedge clk_i) reset = 1'b1;
    @(negedge clk_i) reset = 1'b0;
    vectors++;
    if (pos2 !== 10'd0 || pos1 !== 10'd0) begin
      miscompares++;
      $display("FAIL wrap_clear got pos1=%0d pos2=%0d want 0 0", pos1, pos2);
    end
    start_req(2'd2, 1'b0, 1'b0, 8'd1);
    done_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i); #1;
      if (done && done_k == 0) done_k = k;
    end
    vectors++;
    if (done_k !== 10) begin
      miscompares++;
      $display("FAIL wrap_down_latency got %0d want 10", done_k);
    end
    vectors++;
    if (pos2 !== 10'd1023) begin
      miscompares++;
      $display("FAIL wrap_down_pos got %0d want 1023", pos2);
    end
    start_req(2'd2, 1'b1, 1'b0, 8'd1);
    repeat (12) @(posedge clk_i);
    #1;
    vectors++;
    if (pos2 !== 10'd0) begin
      miscompares++;
      $display("FAIL wrap_up_pos got %0d want 0", pos2);
    end
  endtask

  task automatic test_back_to_back;
    int done_k;
    start_req(2'd0, 1'b1, 1'b0, 8'd2);
    #0;
    vectors++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_busy got ready=%b busy=%b want 0 1", req_ready, busy);
    end
    done_k = 0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(posedge clk_i); #1;
      if (done) done_k = k;
    end
    vectors++;
    if (done_k !== 18) begin
      miscompares++;
      $display("FAIL b2b_first_latency got %0d want 18", done_k);
    end
    vectors++;
    if (req_ready !== 1'b1 || pos0 !== 10'd2) begin
      miscompares++;
      $display("FAIL b2b_first_end got ready=%b pos0=%0d want 1 2", req_ready, pos0);
    end
    start_req(2'd0, 1'b0, 1'b0, 8'd1);
    done_k = 0;
    for (int k = 1; k <= 20 && done_k == 0; k++) begin
      @(posedge clk_i); #1;
      if (done) done_k = k;
    end
    vectors++;
    if (done_k !== 10 || pos0 !== 10'd1) begin
      miscompares++;
      $display("FAIL b2b_second got latency=%0d pos0=%0d want 10 1", done_k, pos0);
    end
  endtask

  task automatic test_zero_steps;
    start_req(2'd0, 1'b1, 1'b0, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk_i); #1;
      vectors++;
      if (phasestep !== 1'b0 || done !== (k == 2)) begin
        miscompares++;
        $display("FAIL zero_steps k=%0d got step=%b done=%b want 0 %b", k, phasestep, done, (k == 2));
      end
    end
    vectors++;
    if (pos0 !== 10'd1) begin
      miscompares++;
      $display("FAIL zero_steps_pos got %0d want 1", pos0);
    end
  endtask

  task automatic test_load;
    start_req(2'd0, 1'b1, 1'b1, 8'd5);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_i); #1;
      vectors++;
      if (phaseloadreg !== (k >= 2 && k < 6) || phasestep !== 1'b0 || done !== (k == 6)) begin
        miscompares++;
        $display("FAIL load k=%0d got load=%b step=%b done=%b want %b 0 %b",
                 k, phaseloadreg, phasestep, done, (k >= 2 && k < 6), (k == 6));
      end
    end
    vectors++;
    if ({pos0, pos1, pos2, pos3} !== {10'd1, 10'd0, 10'd0, 10'd0}) begin
      miscompares++;
      $display("FAIL load_pos got %0d %0d %0d %0d want 1 0 0 0", pos0, pos1, pos2, pos3);
    end
  endtask

  task automatic test_reset_midseq;
    start_req(2'd1, 1'b1, 1'b0, 8'd5);
    repeat (11) @(posedge clk_i);
    #1;
    vectors++;
    if (phasestep !== 1'b1 || pos1 !== 10'd1) begin
      miscompares++;
      $display("FAIL midseq_pulse2 got step=%b pos1=%0d want 1 1", phasestep, pos1);
    end
    @(negedge clk_i) reset = 1'b1;
    @(posedge clk_i); #1;
    vectors++;
    if ({phasestep, phaseloadreg, done, busy, phasesel, phasedir, req_ready} !== 8'd0) begin
      miscompares++;
      $display("FAIL midseq_abort got %b want 00000000",
               {phasestep, phaseloadreg, done, busy, phasesel, phasedir, req_ready});
    end
    vectors++;
    if ({pos0, pos1, pos2, pos3} !== 40'd0) begin
      miscompares++;
      $display("FAIL midseq_pos got %0d %0d %0d %0d want 0 0 0 0", pos0, pos1, pos2, pos3);
    end
    @(negedge clk_i) reset = 1'b0;
    @(posedge clk_i); #1;
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midseq_recover got ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask

`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
  task automatic test_lockwait;
    start_req(2'd3, 1'b1, 1'b0, 8'd3);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) locked = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      @(posedge clk_i); #1;
      vectors++;
      if (phasestep !== (k <= 5) || done !== (k == 6) || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL lockwait k=%0d got step=%b done=%b ready=%b want %b %b 0",
                 k, phasestep, done, req_ready, (k <= 5), (k == 6));
      end
    end
    vectors++;
    if (pos3 !== 10'd1) begin
      miscompares++;
      $display("FAIL lockwait_pos got %0d want 1", pos3);
    end
    @(negedge clk_i) locked = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL lockwait_ready got %b want 1", req_ready);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_steps3;
    test_wrap;
    test_back_to_back;
    test_zero_steps;
    test_load;
    test_reset_midseq;
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
    test_lockwait;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
